// File: rtl/branch_predictor.sv
// Direct-mapped next-PC predictor: 2-bit counters + BTB. Lookup is combinational (0 cycles), mispredict is registered (1 cycle).
// No backpressure: one update can be accepted every cycle, and a lookup in the same cycle sees the entry as it was before the update.
module branch_predictor #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 1;

    logic             valid_q  [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, u_pred, mis_next;
    logic             unused_pc_lsb;

    assign f_idx = fetch_pc[IDX_W:1];
    assign f_tag = fetch_pc[PC_W-1:IDX_W+1];
    assign u_idx = upd_pc[IDX_W:1];
    assign u_tag = upd_pc[PC_W-1:IDX_W+1];
    // PCs are halfword aligned, so bit 0 carries no information.
    assign unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][1];
        pred_target = f_hit ? target_q[f_idx] : '0;
    end

    // Judged against the state the fetch side would have used, i.e. before this update lands.
    always_comb begin
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_pred   = u_hit && ctr_q[u_idx][1];
        mis_next = (u_pred != upd_taken) ||
                   (u_pred && upd_taken && (target_q[u_idx] != upd_target));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'b01;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            mispredict       <= 1'b0;
            mispredict_count <= '0;
        end else begin
            mispredict <= upd_valid && mis_next;
            if (upd_valid) begin
                if (u_hit) begin
                    if (upd_taken) begin
                        if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                        target_q[u_idx] <= upd_target;
                    end else if (ctr_q[u_idx] != 2'b00) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                    end
                end else if (upd_taken) begin
                    // Miss (empty or aliased): a taken branch claims the slot.
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= upd_target;
                    ctr_q[u_idx]    <= 2'b10;
                end
                if (mis_next && (mispredict_count != '1))
                    mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table for lookup/training, then counter saturation and async reset on a narrow-counter instance.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;

    logic        pred_taken, mispredict;
    logic [15:0] pred_target, mispredict_count;
    logic        pred_taken_s, mispredict_s;
    logic [15:0] pred_target_s;
    logic [2:0]  mispredict_count_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .mispredict(mispredict),
        .mispredict_count(mispredict_count)
    );

    branch_predictor #(.PC_W(16), .IDX_W(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken_s), .pred_target(pred_target_s),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .mispredict(mispredict_s),
        .mispredict_count(mispredict_count_s)
    );

    typedef struct {
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic [15:0] fpc;
        logic        ep;
        logic [15:0] et;
        logic        em;
        logic [15:0] ec;
    } vec_t;

    typedef struct {
        logic        m;
        logic [15:0] c;
        logic        chk_s;
        logic [2:0]  cs;
    } sb_t;

    localparam int NV = 22;
    vec_t tbl [NV];
    sb_t  sbq [$];

    function automatic vec_t mk(logic uv, logic [15:0] upc, logic ut, logic [15:0] utgt,
                                logic [15:0] fpc, logic ep, logic [15:0] et,
                                logic em, logic [15:0] ec);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fpc = fpc;
        v.ep = ep; v.et = et; v.em = em; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic [15:0] upc, input logic ut,
                         input logic [15:0] utgt, input logic [15:0] fpc);
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; fetch_pc = fpc;
    endtask

    task automatic pop_check(input string tag);
        sb_t e;
        if (sbq.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".mispredict"}, mispredict, e.m);
        chk({tag, ".count"}, mispredict_count, e.c);
        if (e.chk_s) begin
            chk({tag, ".mispredict_s"}, mispredict_s, e.m);
            chk({tag, ".count_s"}, mispredict_count_s, e.cs);
        end
    endtask

    initial begin
        sb_t  e;
        int   mc;
        int   sc;

        //             uv  upc       ut  utgt      fpc       ep  et        em  ec
        tbl[0]  = mk(0, 16'h0000, 0, 16'h0000, 16'h0040, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 16'h0040, 1, 16'h0100, 16'h0040, 0, 16'h0000, 1, 1);
        tbl[2]  = mk(1, 16'h0040, 1, 16'h0100, 16'h0040, 1, 16'h0100, 0, 1);
        tbl[3]  = mk(1, 16'h0040, 1, 16'h0100, 16'h0040, 1, 16'h0100, 0, 1);
        tbl[4]  = mk(1, 16'h0040, 0, 16'h0000, 16'h0040, 1, 16'h0100, 1, 2);
        tbl[5]  = mk(1, 16'h0040, 0, 16'h0000, 16'h0040, 1, 16'h0100, 1, 3);
        tbl[6]  = mk(1, 16'h0040, 0, 16'h0000, 16'h0040, 0, 16'h0100, 0, 3);
        tbl[7]  = mk(0, 16'h0000, 0, 16'h0000, 16'h0040, 0, 16'h0100, 0, 3);
        tbl[8]  = mk(1, 16'h0060, 1, 16'h0200, 16'h0060, 0, 16'h0000, 1, 4);
        tbl[9]  = mk(0, 16'h0000, 0, 16'h0000, 16'h0040, 0, 16'h0000, 0, 4);
        tbl[10] = mk(0, 16'h0000, 0, 16'h0000, 16'h0060, 1, 16'h0200, 0, 4);
        tbl[11] = mk(1, 16'h0042, 1, 16'h0300, 16'h0042, 0, 16'h0000, 1, 5);
        tbl[12] = mk(0, 16'h0000, 0, 16'h0000, 16'h0042, 1, 16'h0300, 0, 5);
        tbl[13] = mk(1, 16'h0042, 1, 16'h0400, 16'h0042, 1, 16'h0300, 1, 6);
        tbl[14] = mk(1, 16'h0042, 1, 16'h0400, 16'h0042, 1, 16'h0400, 0, 6);
        tbl[15] = mk(1, 16'h0044, 0, 16'h0000, 16'h0044, 0, 16'h0000, 0, 6);
        tbl[16] = mk(1, 16'h0044, 1, 16'h0500, 16'h0044, 0, 16'h0000, 1, 7);
        tbl[17] = mk(1, 16'h0044, 0, 16'h0600, 16'h0044, 1, 16'h0500, 1, 8);
        tbl[18] = mk(0, 16'h0000, 0, 16'h0000, 16'h0044, 0, 16'h0500, 0, 8);
        tbl[19] = mk(1, 16'hFFFE, 1, 16'h1234, 16'hFFFE, 0, 16'h0000, 1, 9);
        tbl[20] = mk(0, 16'h0000, 0, 16'h0000, 16'hFFFE, 1, 16'h1234, 0, 9);
        tbl[21] = mk(0, 16'h0000, 0, 16'h0000, 16'h001E, 0, 16'h0000, 0, 9);

        // Reset state, observed while rst is still high.
        fetch_pc = 16'h0040;
        #1 rst = 1'b1;
        #2;
        chk("reset.pred_taken", pred_taken, 0);
        chk("reset.pred_target", pred_target, 0);
        chk("reset.mispredict", mispredict, 0);
        chk("reset.count", mispredict_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table phase: lookup checked before the edge (pre-update state), registered outputs after.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, tbl[i].fpc);
            #1;
            chk($sformatf("v%0d.pred_taken", i), pred_taken, tbl[i].ep);
            chk($sformatf("v%0d.pred_target", i), pred_target, tbl[i].et);
            e.m = tbl[i].em; e.c = tbl[i].ec; e.chk_s = 1'b0; e.cs = '0;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            pop_check($sformatf("v%0d", i));
        end

        // Saturation phase: fresh reset, then back-to-back mispredicts on one slot
        // (allocate, then taken with a changing target every time).
        @(negedge clk);
        drive(0, 16'h0000, 0, 16'h0000, 16'h0040);
        rst = 1'b1;
        #1 rst = 1'b0;
        mc = 0;
        sc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1, 16'h0040, 1, 16'h0100 + 16'(2 * k), 16'h0040);
            mc = mc + 1;
            sc = (sc == 7) ? 7 : sc + 1;
            e.m = 1'b1; e.c = 16'(mc); e.chk_s = 1'b1; e.cs = 3'(sc);
            sbq.push_back(e);
            @(posedge clk);
            #1;
            pop_check($sformatf("sat%0d", k));
        end

        // Async reset mid-sequence, with an update still being driven.
        #1;
        chk("prerst.pred_taken", pred_taken, 1);
        rst = 1'b1;
        #1;
        chk("arst.pred_taken", pred_taken, 0);
        chk("arst.pred_target", pred_target, 0);
        chk("arst.mispredict", mispredict, 0);
        chk("arst.count", mispredict_count, 0);
        chk("arst.pred_taken_s", pred_taken_s, 0);
        chk("arst.mispredict_s", mispredict_s, 0);
        chk("arst.count_s", mispredict_count_s, 0);
        @(posedge clk);
        #1;
        chk("rsthold.count", mispredict_count, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 16'h0000, 0, 16'h0000, 16'h0040);
        #1;
        chk("postrst.pred_taken", pred_taken, 0);
        chk("postrst.pred_target", pred_target, 0);
        @(posedge clk);
        #1;
        chk("postrst.mispredict", mispredict, 0);
        chk("postrst.count_s", mispredict_count_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
